hpm_counter_bank: RTL and testbench

Parametrised successor to the fixed six-counter performance block. Provides NumCounters programmable mhpmcounter/mhpmevent pairs behind the CSR file's SRAM-like port. Adds multi-increment events (up to NrCommitPorts per cycle), per-privilege inhibit filtering and Sscofpmf-style overflow flag with local overflow interrupt. Sits beside csr_regfile; event sources are pre-aggregated by the caller into a flat event-count vector.

---
 rtl/perf_pkg.sv | 52 +++++
 rtl/hpm_counter.sv | 119 +++++++++++
 rtl/hpm_counter_bank.sv | 124 ++++++++++++
 tb/tb_hpm_counter_bank.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_pkg.sv
// Shared definitions for the hardware performance-monitor counter bank:
// CSR base addresses, mhpmevent field layout and event source numbering.
package perf_pkg;

  localparam logic [11:0] MHPM_COUNTER_3  = 12'hB03;
  localparam logic [11:0] MHPM_COUNTER_3H = 12'hB83;
  localparam logic [11:0] MHPM_EVENT_3    = 12'h323;
  localparam logic [11:0] MHPM_EVENT_3H   = 12'h723;

  // Field positions within the full 64-bit mhpmevent view; with XLEN=32 the
  // upper half is the mhpmeventNh register, so the same positions minus 32 apply.
  localparam int unsigned EVT_UINH_BIT  = 60;
  localparam int unsigned EVT_SINH_BIT  = 61;
  localparam int unsigned EVT_MINH_BIT  = 62;
  localparam int unsigned EVT_OF_BIT    = 63;
  localparam int unsigned EVT_SEL_MAX_W = 8;

  typedef struct packed {
    logic                     of;
    logic                     minh;
    logic                     sinh;
    logic                     uinh;
    logic [EVT_SEL_MAX_W-1:0] sel;
  } hpm_event_t;

  typedef enum logic [4:0] {
    EV_NONE        = 5'd0,
    EV_ICACHE_MISS = 5'd1,
    EV_DCACHE_MISS = 5'd2,
    EV_ITLB_MISS   = 5'd3,
    EV_DTLB_MISS   = 5'd4,
    EV_LOAD        = 5'd5,
    EV_STORE       = 5'd6,
    EV_EXCEPTION   = 5'd7,
    EV_ERET        = 5'd8,
    EV_BRANCH      = 5'd9,
    EV_MISPREDICT  = 5'd10,
    EV_CALL        = 5'd11,
    EV_RETURN      = 5'd12,
    EV_SB_FULL     = 5'd13,
    EV_IF_EMPTY    = 5'd14
  } hpm_event_e;

  typedef enum logic [2:0] {
    CSR_NONE,
    CSR_CNT,
    CSR_CNT_H,
    CSR_EVT,
    CSR_EVT_H
  } hpm_csr_kind_e;

endpackage

// File: rtl/hpm_counter.sv
// One mhpmcounter/mhpmevent pair: event selection, privilege filtering,
// multi-increment with overflow flag, and CSR write merge.
module hpm_counter
  import perf_pkg::*;
#(
  parameter int unsigned CounterWidth  = 64,
  parameter int unsigned NumEvents     = 32,
  parameter int unsigned EventSelWidth = 5,
  parameter int unsigned CntWidth      = 2,
  parameter int unsigned XLEN          = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumEvents*CntWidth-1:0] event_cnt_i,
  input  logic                          count_en_i,
  input  logic [1:0]                    priv_lvl_i,
  input  logic                          cnt_we_i,
  input  logic                          evt_we_i,
  input  logic                          hi_i,
  input  logic [XLEN-1:0]               wdata_i,
  output logic [63:0]                   cnt_o,
  output logic [63:0]                   evt_o,
  output logic                          of_o,
  output logic                          ovf_rise_o
);

  logic [CounterWidth-1:0] cnt_q, cnt_d;
  hpm_event_t              evt_q, evt_d;
  logic [63:0]             wd64, cnt_wr, evt_wr;
  logic [CntWidth-1:0]     inc;
  logic [CounterWidth:0]   sum;
  logic                    priv_inh, count, carry;
  logic                    sel_written, flags_written;
  logic                    unused_wr;

  always_comb begin
    cnt_o = 64'(cnt_q);
    evt_o = '0;
    evt_o[EventSelWidth-1:0] = evt_q.sel[EventSelWidth-1:0];
    evt_o[EVT_UINH_BIT]      = evt_q.uinh;
    evt_o[EVT_SINH_BIT]      = evt_q.sinh;
    evt_o[EVT_MINH_BIT]      = evt_q.minh;
    evt_o[EVT_OF_BIT]        = evt_q.of;
    of_o                     = evt_q.of;
  end

  // Writes are merged into a 64-bit view so both XLEN flavours share one decode.
  always_comb begin
    wd64 = 64'(wdata_i);
    if (XLEN == 64) begin
      cnt_wr        = wd64;
      evt_wr        = wd64;
      sel_written   = evt_we_i;
      flags_written = evt_we_i;
    end else if (hi_i) begin
      cnt_wr        = {wd64[31:0], cnt_o[31:0]};
      evt_wr        = {wd64[31:0], evt_o[31:0]};
      sel_written   = 1'b0;
      flags_written = evt_we_i;
    end else begin
      cnt_wr        = {cnt_o[63:32], wd64[31:0]};
      evt_wr        = {evt_o[63:32], wd64[31:0]};
      sel_written   = evt_we_i;
      flags_written = 1'b0;
    end
  end

  always_comb begin
    inc = (evt_q.sel == '0) ? '0 : event_cnt_i[int'(evt_q.sel)*CntWidth +: CntWidth];
    case (priv_lvl_i)
      2'd3:    priv_inh = evt_q.minh;
      2'd1:    priv_inh = evt_q.sinh;
      2'd0:    priv_inh = evt_q.uinh;
      default: priv_inh = 1'b0;
    endcase
    count = count_en_i && (inc != '0) && !priv_inh;
    sum   = {1'b0, cnt_q} + (CounterWidth+1)'(inc);
    carry = sum[CounterWidth];
  end

  // A counter write replaces this cycle's increment; a written OF overrides overflow.
  always_comb begin
    cnt_d      = cnt_q;
    evt_d      = evt_q;
    ovf_rise_o = 1'b0;
    if (cnt_we_i) begin
      cnt_d = cnt_wr[CounterWidth-1:0];
    end else if (count) begin
      cnt_d = sum[CounterWidth-1:0];
      if (carry) begin
        evt_d.of   = 1'b1;
        ovf_rise_o = !evt_q.of && !flags_written;
      end
    end
    if (sel_written) begin
      evt_d.sel = (evt_wr[59:0] >= 60'(NumEvents)) ? '0
                                                   : EVT_SEL_MAX_W'(evt_wr[EventSelWidth-1:0]);
    end
    if (flags_written) begin
      evt_d.uinh = evt_wr[EVT_UINH_BIT];
      evt_d.sinh = evt_wr[EVT_SINH_BIT];
      evt_d.minh = evt_wr[EVT_MINH_BIT];
      evt_d.of   = evt_wr[EVT_OF_BIT];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      evt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      evt_q <= evt_d;
    end
  end

  always_comb unused_wr = ^{cnt_wr, evt_wr};

endmodule

// File: rtl/hpm_counter_bank.sv
// Bank of NumCounters programmable HPM counters behind the CSR file's
// SRAM-like port: address decode, registered read mux and overflow interrupt.
module hpm_counter_bank
  import perf_pkg::*;
#(
  parameter int unsigned NumCounters   = 6,
  parameter int unsigned CounterWidth  = 64,
  parameter int unsigned NumEvents     = 32,
  parameter int unsigned EventSelWidth = 5,
  parameter int unsigned NrCommitPorts = 2,
  parameter int unsigned XLEN          = 32
) (
  input  logic                                            clk_i,
  input  logic                                            rst_ni,
  input  logic                                            debug_mode_i,
  input  logic [1:0]                                      priv_lvl_i,
  input  logic [11:0]                                     addr_i,
  input  logic                                            we_i,
  input  logic [XLEN-1:0]                                 data_i,
  output logic [XLEN-1:0]                                 data_o,
  output logic                                            access_ex_o,
  input  logic [NumEvents*$clog2(NrCommitPorts+1)-1:0]    event_cnt_i,
  input  logic [31:0]                                     mcountinhibit_i,
  output logic [NumCounters-1:0]                          of_o,
  output logic                                            lcofi_o
);

  localparam int unsigned CntWidth = $clog2(NrCommitPorts + 1);

  hpm_csr_kind_e          kind;
  logic [4:0]             idx;
  logic [11:0]            off_cnt, off_cnth, off_evt, off_evth;
  logic                   hi_sel;
  logic [63:0]            cnt_arr [NumCounters];
  logic [63:0]            evt_arr [NumCounters];
  logic [NumCounters-1:0] rise;
  logic [63:0]            rd_word;
  logic                   unused_bits;

  always_comb begin
    off_cnt  = addr_i - MHPM_COUNTER_3;
    off_cnth = addr_i - MHPM_COUNTER_3H;
    off_evt  = addr_i - MHPM_EVENT_3;
    off_evth = addr_i - MHPM_EVENT_3H;
    kind     = CSR_NONE;
    idx      = '0;
    if (off_cnt < 12'(NumCounters)) begin
      kind = CSR_CNT;
      idx  = off_cnt[4:0];
    end else if (off_evt < 12'(NumCounters)) begin
      kind = CSR_EVT;
      idx  = off_evt[4:0];
    end else if (XLEN == 32 && off_cnth < 12'(NumCounters)) begin
      kind = CSR_CNT_H;
      idx  = off_cnth[4:0];
    end else if (XLEN == 32 && off_evth < 12'(NumCounters)) begin
      kind = CSR_EVT_H;
      idx  = off_evth[4:0];
    end
    hi_sel = (kind == CSR_CNT_H) || (kind == CSR_EVT_H);
  end

  for (genvar n = 0; n < NumCounters; n++) begin : g_cnt
    logic count_en, cnt_we, evt_we;

    always_comb begin
      count_en = !debug_mode_i && !mcountinhibit_i[3+n];
      cnt_we   = we_i && (idx == 5'(n)) && (kind == CSR_CNT || kind == CSR_CNT_H);
      evt_we   = we_i && (idx == 5'(n)) && (kind == CSR_EVT || kind == CSR_EVT_H);
    end

    hpm_counter #(
      .CounterWidth  (CounterWidth),
      .NumEvents     (NumEvents),
      .EventSelWidth (EventSelWidth),
      .CntWidth      (CntWidth),
      .XLEN          (XLEN)
    ) u_counter (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .event_cnt_i (event_cnt_i),
      .count_en_i  (count_en),
      .priv_lvl_i  (priv_lvl_i),
      .cnt_we_i    (cnt_we),
      .evt_we_i    (evt_we),
      .hi_i        (hi_sel),
      .wdata_i     (data_i),
      .cnt_o       (cnt_arr[n]),
      .evt_o       (evt_arr[n]),
      .of_o        (of_o[n]),
      .ovf_rise_o  (rise[n])
    );
  end

  always_comb begin
    rd_word = '0;
    for (int unsigned n = 0; n < NumCounters; n++) begin
      if (idx == 5'(n)) begin
        case (kind)
          CSR_CNT:   rd_word = cnt_arr[n];
          CSR_CNT_H: rd_word = {32'h0, cnt_arr[n][63:32]};
          CSR_EVT:   rd_word = evt_arr[n];
          CSR_EVT_H: rd_word = {32'h0, evt_arr[n][63:32]};
          default:   rd_word = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      data_o      <= '0;
      access_ex_o <= 1'b0;
      lcofi_o     <= 1'b0;
    end else begin
      data_o      <= rd_word[XLEN-1:0];
      access_ex_o <= (kind == CSR_NONE);
      lcofi_o     <= |rise;
    end
  end

  always_comb unused_bits = ^{mcountinhibit_i, rd_word};

endmodule

// File: tb/tb_hpm_counter_bank.sv
// Bench for hpm_counter_bank: an XLEN=32 instance tracked cycle-by-cycle
// by a reference model, plus an XLEN=64 instance for legality checks.
module tb_hpm_counter_bank;

  localparam int unsigned N  = 6;
  localparam int unsigned NE = 32;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, dbg;
  logic [1:0]  priv;
  logic [31:0] inhibit;
  logic [63:0] ev_vec;
  logic [11:0] a32, a64;
  logic        we32, we64;
  logic [31:0] d32, q32;
  logic [63:0] d64, q64;
  logic        ex32, ex64, lcofi32, lcofi64;
  logic [5:0]  of32, of64;

  int unsigned ev [NE];
  int tests = 0;
  int fails = 0;

  logic [63:0] m_cnt [N];
  int unsigned m_sel [N];
  bit          m_u [N], m_s [N], m_m [N], m_of [N];

  hpm_counter_bank #(
    .NumCounters(6), .CounterWidth(64), .NumEvents(32),
    .EventSelWidth(5), .NrCommitPorts(2), .XLEN(32)
  ) dut32 (
    .clk_i(clk), .rst_ni(rst_n), .debug_mode_i(dbg), .priv_lvl_i(priv),
    .addr_i(a32), .we_i(we32), .data_i(d32), .data_o(q32), .access_ex_o(ex32),
    .event_cnt_i(ev_vec), .mcountinhibit_i(inhibit), .of_o(of32), .lcofi_o(lcofi32)
  );

  hpm_counter_bank #(
    .NumCounters(6), .CounterWidth(64), .NumEvents(32),
    .EventSelWidth(5), .NrCommitPorts(2), .XLEN(64)
  ) dut64 (
    .clk_i(clk), .rst_ni(rst_n), .debug_mode_i(dbg), .priv_lvl_i(priv),
    .addr_i(a64), .we_i(we64), .data_i(d64), .data_o(q64), .access_ex_o(ex64),
    .event_cnt_i(ev_vec), .mcountinhibit_i(inhibit), .of_o(of64), .lcofi_o(lcofi64)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // kind: 0 illegal, 1 counter, 2 counter-high, 3 event, 4 event-high
  function automatic void decode(input logic [11:0] addr, output int kind, output int idx);
    int a;
    a    = int'(addr);
    kind = 0;
    idx  = 0;
    if (a >= 'hB03 && a < 'hB03 + N) begin kind = 1; idx = a - 'hB03; end
    if (a >= 'hB83 && a < 'hB83 + N) begin kind = 2; idx = a - 'hB83; end
    if (a >= 'h323 && a < 'h323 + N) begin kind = 3; idx = a - 'h323; end
    if (a >= 'h723 && a < 'h723 + N) begin kind = 4; idx = a - 'h723; end
  endfunction

  // Advance one clock: predict from current inputs, then compare after the edge.
  task automatic step();
    int          kind, idx, inc;
    logic [63:0] n_cnt [N];
    int unsigned n_sel [N];
    bit          n_u [N], n_s [N], n_m [N], n_of [N];
    logic [63:0] sum;
    logic [31:0] e_q;
    logic [5:0]  e_of;
    bit          e_ex, e_l, blocked, cw, ew;
    for (int i = 0; i < NE; i++) ev_vec[2*i +: 2] = 2'(ev[i]);
    decode(a32, kind, idx);
    e_q  = '0;
    e_ex = 1'b0;
    e_l  = 1'b0;
    for (int n = 0; n < N; n++) begin
      n_cnt[n] = '0; n_sel[n] = 0; n_u[n] = 0; n_s[n] = 0; n_m[n] = 0; n_of[n] = 0;
    end
    if (rst_n) begin
      e_ex = (kind == 0);
      case (kind)
        1: e_q = m_cnt[idx][31:0];
        2: e_q = m_cnt[idx][63:32];
        3: e_q = 32'(m_sel[idx]);
        4: e_q = {m_of[idx], m_m[idx], m_s[idx], m_u[idx], 28'h0};
        default: e_q = '0;
      endcase
      for (int n = 0; n < N; n++) begin
        n_cnt[n] = m_cnt[n]; n_sel[n] = m_sel[n];
        n_u[n] = m_u[n]; n_s[n] = m_s[n]; n_m[n] = m_m[n]; n_of[n] = m_of[n];
        inc     = (m_sel[n] == 0) ? 0 : int'(ev[m_sel[n]]);
        blocked = dbg || inhibit[3+n] || (priv == 2'd3 && m_m[n]) ||
                  (priv == 2'd1 && m_s[n]) || (priv == 2'd0 && m_u[n]);
        cw = we32 && idx == n && (kind == 1 || kind == 2);
        ew = we32 && idx == n && (kind == 3 || kind == 4);
        if (cw) begin
          if (kind == 1) n_cnt[n][31:0]  = d32;
          else           n_cnt[n][63:32] = d32;
        end else if (!blocked && inc != 0) begin
          sum = m_cnt[n] + 64'(inc);
          n_cnt[n] = sum;
          if (sum < m_cnt[n]) begin
            n_of[n] = 1;
            if (!m_of[n] && !(ew && kind == 4)) e_l = 1'b1;
          end
        end
        if (ew && kind == 3) n_sel[n] = (d32 < NE) ? int'(d32) : 0;
        if (ew && kind == 4) begin
          n_u[n] = d32[28]; n_s[n] = d32[29]; n_m[n] = d32[30]; n_of[n] = d32[31];
        end
      end
    end
    @(posedge clk);
    #1;
    for (int n = 0; n < N; n++) begin
      m_cnt[n] = n_cnt[n]; m_sel[n] = n_sel[n];
      m_u[n] = n_u[n]; m_s[n] = n_s[n]; m_m[n] = n_m[n]; m_of[n] = n_of[n];
      e_of[n] = n_of[n];
    end
    chk("data_o", q32, e_q);
    chk("access_ex_o", ex32, e_ex);
    chk("lcofi_o", lcofi32, e_l);
    chk("of_o", of32, e_of);
  endtask

  task automatic wr32(input logic [11:0] addr, input logic [31:0] data);
    a32 = addr; d32 = data; we32 = 1'b1;
    step();
    we32 = 1'b0;
  endtask

  task automatic rd32(input logic [11:0] addr, output logic [31:0] data, output logic ex);
    a32 = addr; we32 = 1'b0;
    step();
    data = q32; ex = ex32;
  endtask

  task automatic wr64(input logic [11:0] addr, input logic [63:0] data);
    a64 = addr; d64 = data; we64 = 1'b1;
    step();
    we64 = 1'b0;
  endtask

  task automatic rd64(input logic [11:0] addr, output logic [63:0] data, output logic ex);
    a64 = addr; we64 = 1'b0;
    step();
    data = q64; ex = ex64;
  endtask

  task automatic clear_ev();
    for (int i = 0; i < NE; i++) ev[i] = 0;
  endtask

  initial begin
    logic [31:0] r;
    logic [63:0] r64;
    logic        ex;
    int unsigned privs [3];
    int unsigned sel_k, sel_i;
    privs = '{0, 1, 3};
    rst_n = 1'b0; dbg = 1'b0; priv = 2'd3; inhibit = '0;
    a32 = 12'hB03; we32 = 1'b0; d32 = '0;
    a64 = 12'hB03; we64 = 1'b0; d64 = '0;
    clear_ev();
    step();
    step();
    rst_n = 1'b1;

    // Reset state of every counter and event register.
    for (int i = 0; i < N; i++) begin
      rd32(12'(12'hB03 + i), r, ex); chk("rst_cnt", r, 0); chk("rst_cnt_ex", ex, 0);
      rd32(12'(12'h323 + i), r, ex); chk("rst_evt", r, 0);
    end
    rd64(12'hB03, r64, ex); chk("rst_cnt64", r64, 0); chk("rst_cnt64_ex", ex, 0);

    // LOAD event, two per cycle for ten cycles.
    wr32(12'h323, 32'd5);
    ev[5] = 2;
    for (int i = 0; i < 10; i++) step();
    clear_ev();
    rd32(12'hB03, r, ex); chk("load_count", r, 32'd20);

    // Wrap to 1 with overflow flag and a single lcofi pulse.
    wr32(12'hB04, 32'hFFFF_FFFE);
    wr32(12'hB84, 32'hFFFF_FFFF);
    wr32(12'h324, 32'd1);
    ev[1] = 3;
    step();
    chk("wrap_lcofi_hi", lcofi32, 1);
    chk("wrap_of", of32[1], 1);
    clear_ev();
    step();
    chk("wrap_lcofi_lo", lcofi32, 0);
    rd32(12'hB04, r, ex);  chk("wrap_cnt_lo", r, 32'h1);
    rd32(12'hB84, r, ex);  chk("wrap_cnt_hi", r, 32'h0);
    rd32(12'h724, r, ex);  chk("wrap_of_bit", r[31], 1);

    // Machine-mode inhibit, then user mode, then debug freeze.
    wr32(12'h725, 32'h4000_0000);
    wr32(12'h325, 32'd7);
    ev[7] = 1;
    priv = 2'd3;
    for (int i = 0; i < 5; i++) step();
    priv = 2'd0;
    for (int i = 0; i < 3; i++) step();
    clear_ev();
    rd32(12'hB05, r, ex); chk("minh_count", r, 32'd3);
    dbg = 1'b1; ev[7] = 1;
    for (int i = 0; i < 4; i++) step();
    clear_ev(); dbg = 1'b0; priv = 2'd3;
    rd32(12'hB05, r, ex); chk("debug_freeze", r, 32'd3);

    // Counter write only stalls the written counter.
    wr32(12'h326, 32'd9);
    wr32(12'h327, 32'd9);
    ev[9] = 2;
    for (int i = 0; i < 3; i++) step();
    wr32(12'hB06, 32'd100);
    rd32(12'hB06, r, ex); chk("write_replace", r, 32'd100);
    rd32(12'hB07, r, ex); chk("neighbour_counts", r, 32'd10);
    clear_ev();

    // Illegal addresses and WARL event select.
    rd32(12'hB20, r, ex); chk("oob_ex", ex, 1); chk("oob_data", r, 0);
    wr32(12'h323, 32'd40);
    rd32(12'h323, r, ex); chk("warl_sel", r, 0);
    rd64(12'hB20, r64, ex); chk("oob64_ex", ex, 1); chk("oob64_data", r64, 0);
    rd64(12'hB83, r64, ex); chk("hi64_ex", ex, 1); chk("hi64_data", r64, 0);
    rd64(12'h723, r64, ex); chk("evth64_ex", ex, 1);
    wr64(12'h323, 64'd40);
    rd64(12'h323, r64, ex); chk("warl_sel64", r64, 0); chk("warl_sel64_ex", ex, 0);
    wr64(12'hB03, 64'h1234_5678_9ABC_DEF0);
    wr64(12'h323, 64'h7000_0000_0000_0009);
    rd64(12'h323, r64, ex); chk("evt64_fields", r64, 64'h7000_0000_0000_0009);
    rd64(12'hB03, r64, ex); chk("cnt64_rdback", r64, 64'h1234_5678_9ABC_DEF0);

    // Randomised traffic with counters preloaded close to wrap.
    for (int cyc = 0; cyc < 500; cyc++) begin
      for (int i = 0; i < NE; i++) ev[i] = $urandom_range(0, 2);
      priv    = 2'(privs[$urandom_range(0, 2)]);
      dbg     = ($urandom_range(0, 9) == 0);
      inhibit = $urandom & $urandom & $urandom;
      sel_k   = $urandom_range(0, 9);
      sel_i   = $urandom_range(0, N - 1);
      we32    = ($urandom_range(0, 3) == 0);
      case (sel_k)
        0, 1: begin a32 = 12'(12'hB03 + sel_i); d32 = {28'hFFF_FFFF, 4'($urandom)}; end
        2, 3: begin a32 = 12'(12'hB83 + sel_i);
                    d32 = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : $urandom; end
        4, 5: begin a32 = 12'(12'h323 + sel_i); d32 = $urandom_range(0, 40); end
        6, 7: begin a32 = 12'(12'h723 + sel_i); d32 = $urandom; end
        8:    begin a32 = 12'($urandom); d32 = $urandom; end
        default: begin a32 = 12'(12'hB09 + $urandom_range(0, 22)); d32 = $urandom; end
      endcase
      rst_n = (cyc != 250);
      step();
    end
    rst_n = 1'b1;
    we32  = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
